// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: shares one single-port, synchronous-read RAM between the
// CPU load/store path (c_*) and a DMA/debug master (d_*). Round-robin with an
// optional bounded DMA burst lock. Each transaction is a fixed
// IDLE -> ISSUE -> RESP sequence, so the ack arrives two cycles after the
// request is sampled.
module dmem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 64,
   parameter int MAX_BURST = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         c_req,
   input  logic                         c_we,
   input  logic [31:0]                  c_addr,
   input  logic [DATA_W-1:0]            c_wdata,
   output logic [DATA_W-1:0]            c_rdata,
   output logic                         c_ack,
   output logic                         c_err,
   input  logic                         d_req,
   input  logic                         d_lock,
   input  logic                         d_we,
   input  logic [31:0]                  d_addr,
   input  logic [DATA_W-1:0]            d_wdata,
   output logic [DATA_W-1:0]            d_rdata,
   output logic                         d_ack,
   output logic                         d_err,
   output logic                         mem_we,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic [DATA_W-1:0]            mem_rdata,
   output logic                         busy,
   output logic                         grant_dma
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state, state_nx;
   logic                last_dma;     // winner of the last completed transaction
   logic [BW-1:0]       burst_cnt;    // consecutive locked DMA grants
   logic                lat_dma;
   logic                lat_we;
   logic                lat_err;

   logic                pick_dma;
   logic                sel_we;
   logic                sel_err;
   logic [31:0]         sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                start;
   logic                ack;
   logic [DATA_W-1:0]   rd;

   // Misaligned or beyond the last RAM word: never touches the RAM.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
   endfunction

   // Arbitration: a lone requester wins; on a tie a locked DMA keeps the RAM
   // for up to MAX_BURST grants, otherwise the other side gets its turn.
   always_comb begin
      pick_dma = d_req;
      if (c_req && d_req) begin
         if (d_lock && last_dma && (burst_cnt < BW'(MAX_BURST)))
            pick_dma = 1'b1;
         else
            pick_dma = !last_dma;
      end
      sel_we    = pick_dma ? d_we    : c_we;
      sel_addr  = pick_dma ? d_addr  : c_addr;
      sel_wdata = pick_dma ? d_wdata : c_wdata;
      sel_err   = addr_bad(sel_addr);
      start     = (state == IDLE) && (c_req || d_req);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and outputs. Acks are masked while reset is high so a
   // transaction killed in RESP never completes; a write already on the RAM
   // port in ISSUE is left alone.
   always_comb begin
      state_nx  = state;
      mem_we    = 1'b0;
      busy      = (state != IDLE);
      ack       = 1'b0;
      c_ack     = 1'b0;
      d_ack     = 1'b0;
      c_err     = 1'b0;
      d_err     = 1'b0;
      c_rdata   = '0;
      d_rdata   = '0;
      rd        = (!lat_we && !lat_err) ? mem_rdata : '0;
      case (state)
         IDLE:  if (c_req || d_req) state_nx = ISSUE;
         ISSUE: begin
            mem_we   = lat_we && !lat_err;
            state_nx = RESP;
         end
         RESP: begin
            ack      = !reset;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      c_ack   = ack && !lat_dma;
      d_ack   = ack &&  lat_dma;
      c_err   = c_ack && lat_err;
      d_err   = d_ack && lat_err;
      c_rdata = c_ack ? rd : '0;
      d_rdata = d_ack ? rd : '0;
   end

   // Latch the winning request; the RAM address/data registers only move for
   // error-free requests so they hold their last values otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_dma  <= 1'b1;
         burst_cnt <= '0;
         lat_dma   <= 1'b0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (start) begin
            lat_dma <= pick_dma;
            lat_we  <= sel_we;
            lat_err <= sel_err;
            if (!sel_err) begin
               mem_addr  <= sel_addr[AW+1:2];
               mem_wdata <= sel_wdata;
            end
            if (pick_dma && d_lock)
               burst_cnt <= (burst_cnt == BW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
            else
               burst_cnt <= '0;
         end
         if (state == RESP) last_dma <= lat_dma;
      end
   end

   assign grant_dma = lat_dma;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural RAM, a transaction-level reference
// model, a per-cycle compare process, directed scenarios with literal
// expectations, then randomized traffic with occasional resets.
module tb_dmem_arbiter;

   localparam int DATA_W    = 32;
   localparam int MEM_WORDS = 64;
   localparam int MAX_BURST = 4;
   localparam int AW        = $clog2(MEM_WORDS);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              c_req = 1'b0, c_we = 1'b0;
   logic [31:0]       c_addr = '0;
   logic [DATA_W-1:0] c_wdata = '0;
   logic [DATA_W-1:0] c_rdata;
   logic              c_ack, c_err;
   logic              d_req = 1'b0, d_lock = 1'b0, d_we = 1'b0;
   logic [31:0]       d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack, d_err;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy, grant_dma;

   int n_chk = 0;
   int n_fail = 0;

   dmem_arbiter #(.DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ack(c_ack), .c_err(c_err),
      .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant_dma(grant_dma)
   );

   always #5 clk = ~clk;

   // RAM with synchronous read
   logic [DATA_W-1:0] ram [MEM_WORDS];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // m_age: -1 free, 1 = cycle of RAM access, 2 = cycle of completion.
   logic [DATA_W-1:0] mmem [MEM_WORDS];
   int                m_age = -1;
   bit                m_last_dma = 1'b1;
   int                m_cnt = 0;
   bit                m_gnt = 1'b0;
   logic [AW-1:0]     m_maddr = '0;
   logic [DATA_W-1:0] m_mwdata = '0;
   bit                t_dma = 1'b0, t_we = 1'b0, t_err = 1'b0;
   int unsigned       t_idx = 0;
   logic [DATA_W-1:0] t_wdata = '0, t_rdata = '0;
   logic [31:0]       m_a;

   always @(posedge clk) begin
      if (reset) begin
         m_age = -1; m_last_dma = 1'b1; m_cnt = 0; m_gnt = 1'b0;
         m_maddr = '0; m_mwdata = '0;
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (m_age == 2) begin
         m_last_dma = t_dma;
         m_age = -1;
      end else if (c_req || d_req) begin
         if (c_req && d_req)
            t_dma = (d_lock && m_last_dma && m_cnt < MAX_BURST) ? 1'b1 : !m_last_dma;
         else
            t_dma = d_req;
         m_a     = t_dma ? d_addr : c_addr;
         t_we    = t_dma ? d_we : c_we;
         t_wdata = t_dma ? d_wdata : c_wdata;
         t_err   = (m_a % 4 != 0) || (m_a / 4 >= MEM_WORDS);
         t_idx   = (m_a / 4) % MEM_WORDS;
         if (t_dma && d_lock) m_cnt = (m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1;
         else                 m_cnt = 0;
         t_rdata = (!t_we && !t_err) ? mmem[t_idx] : '0;
         if (!t_err) begin
            m_maddr  = AW'(t_idx);
            m_mwdata = t_wdata;
            if (t_we) mmem[t_idx] = t_wdata;
         end
         m_gnt = t_dma;
         m_age = 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      bit ea;
      ea = (m_age == 2) && !reset;
      chk("busy",      busy,      m_age != -1);
      chk("grant_dma", grant_dma, m_gnt);
      chk("mem_we",    mem_we,    (m_age == 1) && t_we && !t_err);
      chk("mem_addr",  mem_addr,  m_maddr);
      chk("mem_wdata", mem_wdata, m_mwdata);
      chk("c_ack",     c_ack,     ea && !t_dma);
      chk("d_ack",     d_ack,     ea && t_dma);
      chk("c_err",     c_err,     ea && !t_dma && t_err);
      chk("d_err",     d_err,     ea && t_dma && t_err);
      chk("c_rdata",   c_rdata,   (ea && !t_dma) ? t_rdata : '0);
      chk("d_rdata",   d_rdata,   (ea && t_dma) ? t_rdata : '0);
      chk("ack_excl",  c_ack & d_ack, 0);
   end

   // ---------------- stimulus ----------------
   task automatic at_neg(); @(negedge clk); endtask
   task automatic at_pos(); @(posedge clk); #1; endtask
   task automatic do_reset();
      at_pos(); reset = 1'b1;
      at_pos(); reset = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r == 0) return $urandom;
      if (r == 1) return 32'($urandom_range(0, MEM_WORDS-1) * 4 + $urandom_range(1, 3));
      if (r == 2) return 32'((MEM_WORDS + $urandom_range(0, 7)) * 4);
      return 32'($urandom_range(0, MEM_WORDS-1) * 4);
   endfunction

   int          n;
   logic [7:0]  seq;
   logic        saw_we, ca, da;

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) begin
         ram[i]  <= 32'hC0DE0000 + 32'(i);
         mmem[i]  = 32'hC0DE0000 + 32'(i);
      end
      repeat (2) at_pos();
      reset = 1'b0;

      // reset state
      at_neg();
      chk("rst_busy", busy, 0);
      chk("rst_outs", {c_ack, d_ack, c_err, d_err, mem_we, grant_dma}, 0);
      chk("rst_addr", mem_addr, 0);

      // CPU alone: store 7 to 84, then load it back
      at_pos(); c_req = 1; c_we = 1; c_addr = 84; c_wdata = 7;
      at_pos(); at_neg();
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 21);
      chk("wr_early_ack", c_ack, 0);
      at_neg();
      chk("wr_c_ack", c_ack, 1);
      chk("wr_c_err", c_err, 0);
      at_pos(); c_we = 0;
      at_pos(); at_neg();
      chk("rd_mem_we", mem_we, 0);
      at_neg();
      chk("rd_c_ack", c_ack, 1);
      chk("rd_c_rdata", c_rdata, 7);
      at_pos(); c_req = 0;

      // simultaneous requests without lock alternate CPU, DMA, ...
      do_reset();
      c_req = 1; c_we = 1; c_addr = 128; c_wdata = 32'hA0;
      d_req = 1; d_we = 1; d_addr = 192; d_wdata = 32'hB0; d_lock = 0;
      n = 0; seq = '0;
      for (int k = 0; k < 60 && n < 8; k++) begin
         at_neg();
         if (c_ack || d_ack) begin
            seq[n[2:0]] = d_ack;
            n++;
            if (c_ack) begin c_addr += 4; c_wdata += 1; end
            else       begin d_addr += 4; d_wdata += 1; end
         end
      end
      c_req = 0; d_req = 0;
      chk("alt_count", n, 8);
      chk("alt_seq", seq, 8'b1010_1010);

      // locked DMA burst: 4 DMA grants, then the waiting CPU, then DMA again
      do_reset();
      d_req = 1; d_lock = 1; d_we = 1; d_addr = 0; d_wdata = 32'h100;
      c_we = 0; c_addr = 100;
      n = 0; seq = '0;
      for (int k = 0; k < 80 && n < 6; k++) begin
         at_neg();
         if (n == 0 && busy && grant_dma && !c_req) c_req = 1;
         if (d_ack) begin
            seq[n[2:0]] = 1'b1; n++; d_addr += 4; d_wdata += 1;
         end else if (c_ack) begin
            seq[n[2:0]] = 1'b0; n++; c_req = 0;
         end
      end
      d_req = 0; d_lock = 0; c_req = 0;
      chk("burst_count", n, 6);
      chk("burst_seq", seq[5:0], 6'b10_1111);

      // misaligned CPU load
      do_reset();
      c_req = 1; c_we = 0; c_addr = 86;
      at_pos(); at_neg();
      saw_we = mem_we;
      at_neg();
      chk("mis_mem_we", saw_we | mem_we, 0);
      chk("mis_c_ack", c_ack, 1);
      chk("mis_c_err", c_err, 1);
      chk("mis_c_rdata", c_rdata, 0);
      at_pos(); c_req = 0;
      // out-of-range DMA store must leave the RAM alone
      d_req = 1; d_we = 1; d_addr = 256; d_wdata = 32'hDEADBEEF;
      at_pos(); at_neg();
      saw_we = mem_we;
      at_neg();
      chk("oor_mem_we", saw_we | mem_we, 0);
      chk("oor_d_ack", d_ack, 1);
      chk("oor_d_err", d_err, 1);
      at_pos(); d_req = 0;
      at_pos();
      chk("oor_ram0", ram[0], 32'h100);

      // reset during the completion cycle of a DMA load
      d_req = 1; d_we = 0; d_addr = 8;
      at_pos(); at_pos();
      reset = 1;
      at_neg();
      chk("rmid_no_ack", d_ack, 0);
      d_req = 0;
      at_pos(); reset = 0;
      at_neg();
      chk("rmid_idle", {busy, c_ack, d_ack, c_err, d_err, mem_we, grant_dma}, 0);
      chk("rmid_data", {c_rdata, d_rdata}, 0);
      chk("rmid_maddr", mem_addr, 0);
      at_pos(); c_req = 1; c_we = 0; c_addr = 8;
      at_pos(); at_neg();
      chk("rmid_cpu_addr", mem_addr, 2);
      at_neg();
      chk("rmid_cpu_ack", c_ack, 1);
      chk("rmid_cpu_rdata", c_rdata, 32'h102);
      at_pos(); c_req = 0;

      // inputs churn after the request is latched
      at_pos(); c_req = 1; c_we = 1; c_addr = 84; c_wdata = 32'h55;
      at_pos(); c_addr = 88; c_wdata = 32'h66;
      at_neg();
      chk("churn_addr", mem_addr, 21);
      chk("churn_wdata", mem_wdata, 32'h55);
      at_neg();
      chk("churn_ack", c_ack, 1);
      at_pos(); c_req = 0;
      at_pos();
      chk("churn_ram21", ram[21], 32'h55);
      chk("churn_ram22", ram[22], 32'hC0DE0016);

      // randomized traffic honoring the requester protocol
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         at_neg();
         ca = c_ack; da = d_ack;
         at_pos();
         reset = ($urandom_range(0, 199) == 0);
         if (ca || !c_req) begin
            c_req = ca ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 3);
            c_we = 1'($urandom_range(0, 1)); c_addr = rnd_addr(); c_wdata = $urandom;
         end
         if (da || !d_req) begin
            d_req = da ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 3);
            d_lock = ($urandom_range(0, 9) < 6);
            d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
         end
      end
      reset = 0; c_req = 0; d_req = 0;
      repeat (5) at_pos();
      for (int i = 0; i < MEM_WORDS; i++) chk("ram_final", ram[i], mmem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
